// File: rtl/axi_ram_write_slave.sv
// AXI4 write-channel slave that commits accepted beats into a word-addressed
// single-port RAM through a registered, byte-masked write port.
// One burst in flight: AW -> W beats -> B, then back to IDLE.
module axi_ram_write_slave #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int RAM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       axi_aw_awid,
  input  logic [ADDR_W-1:0]     axi_aw_awaddr,
  input  logic [2:0]            axi_aw_awsize,
  input  logic [7:0]            axi_aw_awlen,
  input  logic [1:0]            axi_aw_awburst,
  input  logic                  axi_aw_awvalid,
  output logic                  axi_aw_awready,
  input  logic [DATA_W-1:0]     axi_w_wdata,
  input  logic [DATA_W/8-1:0]   axi_w_wstrb,
  input  logic                  axi_w_wlast,
  input  logic                  axi_w_wvalid,
  output logic                  axi_w_wready,
  output logic [2:0]            axi_b_bresp,
  output logic [ID_W-1:0]       axi_b_bid,
  output logic                  axi_b_bvalid,
  input  logic                  axi_b_bready,
  output logic                  ram_wr_en,
  output logic [RAM_ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_data,
  output logic [DATA_W/8-1:0]   ram_wr_mask
);

  localparam int WA_W   = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [ID_W-1:0]         id_r;
  logic [7:0]              len_r;
  logic [1:0]              burst_r;
  logic [WA_W-1:0]         waddr_r;
  logic [8:0]              beat_r;
  logic [1:0]              err_r;
  logic                    awready_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic                    ram_wr_en_r;
  logic [RAM_ADDR_W-1:0]   ram_wr_addr_r;
  logic [DATA_W-1:0]       ram_wr_data_r;
  logic [STRB_W-1:0]       ram_wr_mask_r;

  logic                    w_hs_s;
  logic                    in_range_s;
  logic                    last_beat_s;
  logic                    write_ok_s;
  logic [1:0]              err_next_s;

  assign w_hs_s      = wready_r & axi_w_wvalid;
  // Word address fits the RAM only when every bit above RAM_ADDR_W is clear.
  assign in_range_s  = ((waddr_r >> RAM_ADDR_W) == {WA_W{1'b0}});
  assign last_beat_s = (beat_r == {1'b0, len_r});
  // The write decision uses the error state accumulated before this beat.
  assign write_ok_s  = (err_r != RESP_SLVERR) && in_range_s;

  // Error after the current beat: decode error for out-of-range beats, slave error for wlast mismatch (wins).
  always_comb begin
    err_next_s = err_r;
    if ((err_r != RESP_SLVERR) && !in_range_s) begin
      err_next_s = RESP_DECERR;
    end else begin
      err_next_s = err_r;
    end
    if (axi_w_wlast != last_beat_s) begin
      err_next_s = RESP_SLVERR;
    end else begin
      err_next_s = err_next_s;
    end
  end

  // Burst FSM with registered handshake outputs and registered RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      id_r          <= {ID_W{1'b0}};
      len_r         <= 8'd0;
      burst_r       <= 2'd0;
      waddr_r       <= {WA_W{1'b0}};
      beat_r        <= 9'd0;
      err_r         <= RESP_OKAY;
      awready_r     <= 1'b0;
      wready_r      <= 1'b0;
      bvalid_r      <= 1'b0;
      ram_wr_en_r   <= 1'b0;
      ram_wr_addr_r <= {RAM_ADDR_W{1'b0}};
      ram_wr_data_r <= {DATA_W{1'b0}};
      ram_wr_mask_r <= {STRB_W{1'b0}};
    end else begin
      ram_wr_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (awready_r && axi_aw_awvalid) begin
            id_r      <= axi_aw_awid;
            len_r     <= axi_aw_awlen;
            burst_r   <= axi_aw_awburst;
            waddr_r   <= axi_aw_awaddr[ADDR_W-1:2];
            beat_r    <= 9'd0;
            err_r     <= ((axi_aw_awsize != 3'd2) || (axi_aw_awburst > 2'd1)) ? RESP_SLVERR : RESP_OKAY;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            state_r   <= DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        DATA: begin
          if (w_hs_s) begin
            beat_r <= beat_r + 9'd1;
            err_r  <= err_next_s;
            if (write_ok_s) begin
              ram_wr_en_r   <= 1'b1;
              ram_wr_addr_r <= waddr_r[RAM_ADDR_W-1:0];
              ram_wr_data_r <= axi_w_wdata;
              ram_wr_mask_r <= axi_w_wstrb;
            end
            if (burst_r == BURST_INCR) begin
              waddr_r <= waddr_r + WA_W'(1);
            end
            if (last_beat_s) begin
              wready_r <= 1'b0;
              bvalid_r <= 1'b1;
              state_r  <= RESP;
            end
          end
        end
        RESP: begin
          if (bvalid_r && axi_b_bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          awready_r <= 1'b0;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign axi_aw_awready = awready_r;
  assign axi_w_wready   = wready_r;
  assign axi_b_bvalid   = bvalid_r;
  assign axi_b_bresp    = {1'b0, err_r};
  assign axi_b_bid      = id_r;
  assign ram_wr_en      = ram_wr_en_r;
  assign ram_wr_addr    = ram_wr_addr_r;
  assign ram_wr_data    = ram_wr_data_r;
  assign ram_wr_mask    = ram_wr_mask_r;

endmodule

// File: tb/tb_axi_ram_write_slave.sv
// Scoreboard bench for axi_ram_write_slave: directed bursts push expected RAM
// writes and B responses into queues; a negedge monitor pops and compares.
module tb_axi_ram_write_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = 4'd0;
  logic [15:0] awaddr = 16'd0;
  logic [2:0]  awsize = 3'd0;
  logic [7:0]  awlen = 8'd0;
  logic [1:0]  awburst = 2'd0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [2:0]  bresp;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_wr_mask;

  int total = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } wexp_t;

  typedef struct {
    logic [3:0] id;
    logic [2:0] resp;
  } bexp_t;

  wexp_t wq[$];
  bexp_t bq[$];

  axi_ram_write_slave dut (
    .clk(clk), .rst(rst),
    .axi_aw_awid(awid), .axi_aw_awaddr(awaddr), .axi_aw_awsize(awsize),
    .axi_aw_awlen(awlen), .axi_aw_awburst(awburst), .axi_aw_awvalid(awvalid),
    .axi_aw_awready(awready),
    .axi_w_wdata(wdata), .axi_w_wstrb(wstrb), .axi_w_wlast(wlast),
    .axi_w_wvalid(wvalid), .axi_w_wready(wready),
    .axi_b_bresp(bresp), .axi_b_bid(bid), .axi_b_bvalid(bvalid), .axi_b_bready(bready),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_mask(ram_wr_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m, input logic l);
    wexp_t e;
    e.addr = a; e.data = d; e.mask = m; e.last = l;
    wq.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [2:0] resp);
    bexp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endtask

  // Monitor: compare every RAM write and every B handshake against the queues.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      total++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", ram_wr_addr, ram_wr_data);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        if (ram_wr_addr !== e.addr || ram_wr_data !== e.data || ram_wr_mask !== e.mask) begin
          fails++;
          $display("FAIL wr_beat: got %0h/%0h/%0h, expected %0h/%0h/%0h",
                   ram_wr_addr, ram_wr_data, ram_wr_mask, e.addr, e.data, e.mask);
        end
        if (e.last) check("bvalid_with_last_wr", 64'(bvalid), 64'd1);
      end
    end
    if (bvalid && bready) begin
      total++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected: got bid %0h bresp %0h, expected none", bid, bresp);
      end else begin
        bexp_t e;
        e = bq.pop_front();
        if (bid !== e.id || bresp !== e.resp) begin
          fails++;
          $display("FAIL b_resp: got bid %0h bresp %0h, expected bid %0h bresp %0h", bid, bresp, e.id, e.resp);
        end
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [15:0] addr, input logic [2:0] size,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    logic hs;
    awid = id; awaddr = addr; awsize = size; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
    int n;
    logic hs;
    wvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0; hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk); hs = wready;
      @(posedge clk); #1; n++;
    end
    wvalid = 1'b0;
    check("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic wait_b(input logic [3:0] id, input int delay);
    int n;
    logic seen;
    bready = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk); seen = bvalid;
      if (!seen) begin @(posedge clk); #1; end
      n++;
    end
    check("bvalid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("bid_stable", 64'(bid), 64'(id));
      check("bvalid_held", 64'(bvalid), 64'd1);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_ram_wr_en", 64'(ram_wr_en), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single beat write
    push_w(10'h004, 32'hDEADBEEF, 4'hF, 1'b1); push_b(4'd3, 3'd0);
    send_aw(4'd3, 16'h0010, 3'd2, 8'd0, 2'd1);
    send_w(32'hDEADBEEF, 4'hF, 1'b1, 0);
    wait_b(4'd3, 0);

    // INCR burst, back-to-back beats
    push_w(10'h040, 32'h11111111, 4'h1, 1'b0);
    push_w(10'h041, 32'h22222222, 4'h3, 1'b0);
    push_w(10'h042, 32'h33333333, 4'hC, 1'b0);
    push_w(10'h043, 32'h44444444, 4'hF, 1'b1);
    push_b(4'd5, 3'd0);
    send_aw(4'd5, 16'h0100, 3'd2, 8'd3, 2'd1);
    send_w(32'h11111111, 4'h1, 1'b0, 0);
    send_w(32'h22222222, 4'h3, 1'b0, 0);
    send_w(32'h33333333, 4'hC, 1'b0, 0);
    send_w(32'h44444444, 4'hF, 1'b1, 0);
    wait_b(4'd5, 0);

    // FIXED burst with wvalid gaps, late bready; zero strobe still writes
    push_w(10'h008, 32'hA0A0A0A0, 4'h5, 1'b0);
    push_w(10'h008, 32'hB1B1B1B1, 4'h0, 1'b0);
    push_w(10'h008, 32'hC2C2C2C2, 4'hA, 1'b1);
    push_b(4'd7, 3'd0);
    send_aw(4'd7, 16'h0020, 3'd2, 8'd2, 2'd0);
    send_w(32'hA0A0A0A0, 4'h5, 1'b0, 2);
    send_w(32'hB1B1B1B1, 4'h0, 1'b0, 3);
    send_w(32'hC2C2C2C2, 4'hA, 1'b1, 1);
    wait_b(4'd7, 5);

    // Unsupported size: no writes, SLVERR
    push_b(4'd1, 3'd2);
    send_aw(4'd1, 16'h0000, 3'd1, 8'd1, 2'd1);
    send_w(32'h12345678, 4'hF, 1'b0, 0);
    send_w(32'h9ABCDEF0, 4'hF, 1'b1, 0);
    wait_b(4'd1, 0);

    // Unsupported burst type: SLVERR
    push_b(4'd2, 3'd2);
    send_aw(4'd2, 16'h0000, 3'd2, 8'd0, 2'd2);
    send_w(32'h0BADF00D, 4'hF, 1'b1, 0);
    wait_b(4'd2, 0);

    // Burst running off the end of the RAM: last in-range word written, then DECERR
    push_w(10'h3FF, 32'hCAFEF00D, 4'hF, 1'b0);
    push_b(4'd4, 3'd3);
    send_aw(4'd4, 16'h0FFC, 3'd2, 8'd1, 2'd1);
    send_w(32'hCAFEF00D, 4'hF, 1'b0, 0);
    send_w(32'hFEEDFACE, 4'hF, 1'b1, 0);
    wait_b(4'd4, 0);

    // Early wlast: first beat written, SLVERR blocks the second, both consumed
    push_w(10'h010, 32'h55AA55AA, 4'hF, 1'b0);
    push_b(4'd6, 3'd2);
    send_aw(4'd6, 16'h0040, 3'd2, 8'd1, 2'd1);
    send_w(32'h55AA55AA, 4'hF, 1'b1, 0);
    send_w(32'hAA55AA55, 4'hF, 1'b0, 0);
    wait_b(4'd6, 0);

    // Reset after beat 1 of a len=3 burst: beat 1 write cancelled, no B
    push_w(10'h080, 32'h01020304, 4'hF, 1'b0);
    send_aw(4'd9, 16'h0200, 3'd2, 8'd3, 2'd1);
    send_w(32'h01020304, 4'hF, 1'b0, 0);
    send_w(32'h05060708, 4'hF, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("midrst_ram_wr_en", 64'(ram_wr_en), 64'd0);
    check("midrst_wready", 64'(wready), 64'd0);
    check("midrst_bvalid", 64'(bvalid), 64'd0);
    check("midrst_ram_wr_addr", 64'(ram_wr_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    push_w(10'h00C, 32'h76543210, 4'h3, 1'b1); push_b(4'hA, 3'd0);
    send_aw(4'hA, 16'h0030, 3'd2, 8'd0, 2'd1);
    send_w(32'h76543210, 4'h3, 1'b1, 0);
    wait_b(4'hA, 2);

    repeat (3) @(posedge clk);
    #1;
    check("wq_drained", 64'(wq.size()), 64'd0);
    check("bq_drained", 64'(bq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", total, fails);
    $finish;
  end

endmodule
